fractal_sync_rr_sched: RTL and testbench

//  Fair, backpressure-aware scheduler sharing IN_PORTS FIFO-style sources (empty/element/pop) among OUT_PORTS

---
 rtl/fractal_sync_rr_sched.sv | 147 ++++++++++++++
 tb/tb_fractal_sync_rr_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_rr_sched.sv
// fractal_sync_rr_sched: rotating-priority, aging, lock-until-accepted
// scheduler moving FIFO heads from IN_PORTS sources to OUT_PORTS sinks.
module fractal_sync_rr_sched #(
  parameter int unsigned IN_PORTS  = 4,
  parameter int unsigned OUT_PORTS = 2,
  parameter type         arbiter_t = logic,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IN_PORTS-1:0]  empty_i,
  input  arbiter_t             element_i [IN_PORTS],
  output logic [IN_PORTS-1:0]  pop_o,
  output arbiter_t             element_o [OUT_PORTS],
  output logic [OUT_PORTS-1:0] valid_o,
  input  logic [OUT_PORTS-1:0] ready_i,
  output logic [IN_PORTS-1:0]  starve_o
);

  localparam int unsigned IDX_W =
    (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [AGE_W-1:0] age_t;

  if (OUT_PORTS < 1 || OUT_PORTS > IN_PORTS || MAX_WAIT < 1)
  begin : g_bad_cfg
    $error("fractal_sync_rr_sched: bad parameters");
  end

  idx_t                 ptr_q, ptr_d;
  logic [OUT_PORTS-1:0] lock_q;
  idx_t                 lock_src_q [OUT_PORTS];
  age_t                 wait_q [IN_PORTS];

  idx_t                 src [OUT_PORTS];
  logic [OUT_PORTS-1:0] valid;
  logic [OUT_PORTS-1:0] take;
  logic [IN_PORTS-1:0]  claimed;
  logic [IN_PORTS-1:0]  aged;
  logic [IN_PORTS-1:0]  pop;
  int                   scan;
  idx_t                 cand;

  // A source is aged once its wait counter saturates
  always_comb begin
    aged = '0;
    for (int i = 0; i < IN_PORTS; i++)
      aged[i] = (wait_q[i] == age_t'(MAX_WAIT));
  end

  // Resolve sinks in order: locks, then aged, then rotating scan
  always_comb begin
    claimed = '0;
    valid   = '0;
    pop     = '0;
    scan    = 0;
    cand    = '0;
    for (int j = 0; j < OUT_PORTS; j++) begin
      src[j]       = '0;
      element_o[j] = '0;
    end
    for (int j = 0; j < OUT_PORTS; j++)
      if (lock_q[j]) claimed[lock_src_q[j]] = 1'b1;
    for (int j = 0; j < OUT_PORTS; j++) begin
      if (lock_q[j]) begin
        src[j]   = lock_src_q[j];
        valid[j] = 1'b1;
      end else begin
        for (int i = 0; i < IN_PORTS; i++) begin
          cand = idx_t'(i);
          if (!valid[j] && aged[cand] &&
              !empty_i[cand] && !claimed[cand]) begin
            src[j]   = cand;
            valid[j] = 1'b1;
          end
        end
        for (int k = 0; k < IN_PORTS; k++) begin
          scan = int'(ptr_q) + k;
          if (scan >= int'(IN_PORTS))
            scan = scan - int'(IN_PORTS);
          cand = idx_t'(scan);
          if (!valid[j] && !empty_i[cand] &&
              !claimed[cand]) begin
            src[j]   = cand;
            valid[j] = 1'b1;
          end
        end
        if (valid[j]) claimed[src[j]] = 1'b1;
      end
      if (valid[j]) begin
        element_o[j] = element_i[src[j]];
        if (ready_i[j] && rst_ni) pop[src[j]] = 1'b1;
      end
    end
  end

  assign take     = valid & ready_i;
  assign valid_o  = valid;
  assign pop_o    = pop;
  assign starve_o = aged;

  // Pointer follows the highest-index sink that popped
  always_comb begin
    ptr_d = ptr_q;
    for (int j = 0; j < OUT_PORTS; j++)
      if (take[j])
        ptr_d = (src[j] == idx_t'(IN_PORTS - 1)) ?
                '0 : src[j] + 1'b1;
  end

  // Pointer, lock and aging state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      lock_q <= '0;
      for (int j = 0; j < OUT_PORTS; j++)
        lock_src_q[j] <= '0;
      for (int i = 0; i < IN_PORTS; i++)
        wait_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int j = 0; j < OUT_PORTS; j++) begin
        if (valid[j] && !ready_i[j]) begin
          lock_q[j]     <= 1'b1;
          lock_src_q[j] <= src[j];
        end else if (valid[j]) begin
          lock_q[j] <= 1'b0;
        end
      end
      for (int i = 0; i < IN_PORTS; i++) begin
        if (pop[i] || empty_i[i])
          wait_q[i] <= '0;
        else if (!aged[i])
          wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  for (genvar j = 0; j < OUT_PORTS; j++) begin : g_lock_chk
    a_lock_src_full: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      lock_q[j] |-> !empty_i[lock_src_q[j]]);
  end

endmodule

// File: tb/tb_fractal_sync_rr_sched.sv
// tb_fractal_sync_rr_sched: directed vectors for the
// fractal_sync round-robin scheduler (2-sink and 1-sink builds).
module tb_fractal_sync_rr_sched;

  typedef struct {
    logic [3:0] empty;
    logic [1:0] ready;
    logic [1:0] valid;
    logic [3:0] pop;
    logic [3:0] starve;
    logic [7:0] el0;
    logic [7:0] el1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ei [4];

  logic [3:0] empty1;
  logic [1:0] ready1;
  logic [3:0] pop1;
  logic [7:0] eo1 [2];
  logic [1:0] valid1;
  logic [3:0] starve1;

  logic [3:0] empty2;
  logic [0:0] ready2;
  logic [3:0] pop2;
  logic [7:0] eo2 [1];
  logic [0:0] valid2;
  logic [3:0] starve2;

  int nchk = 0;
  int nfail = 0;

  vec_t v1 [17];
  vec_t v2 [6];

  always #5 clk = ~clk;

  fractal_sync_rr_sched #(
    .IN_PORTS (4),
    .OUT_PORTS(2),
    .arbiter_t(logic [7:0]),
    .MAX_WAIT (8)
  ) dut1 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .empty_i  (empty1),
    .element_i(ei),
    .pop_o    (pop1),
    .element_o(eo1),
    .valid_o  (valid1),
    .ready_i  (ready1),
    .starve_o (starve1)
  );

  fractal_sync_rr_sched #(
    .IN_PORTS (4),
    .OUT_PORTS(1),
    .arbiter_t(logic [7:0]),
    .MAX_WAIT (2)
  ) dut2 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .empty_i  (empty2),
    .element_i(ei),
    .pop_o    (pop2),
    .element_o(eo2),
    .valid_o  (valid2),
    .ready_i  (ready2),
    .starve_o (starve2)
  );

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input vec_t v);
    chk({tag, " valid"}, {6'd0, valid1}, {6'd0, v.valid});
    chk({tag, " pop"}, {4'd0, pop1}, {4'd0, v.pop});
    chk({tag, " starve"}, {4'd0, starve1}, {4'd0, v.starve});
    chk({tag, " el0"}, eo1[0], v.el0);
    chk({tag, " el1"}, eo1[1], v.el1);
  endtask

  task automatic chk2(input string tag, input vec_t v);
    chk({tag, " valid"}, {7'd0, valid2}, {7'd0, v.valid[0]});
    chk({tag, " pop"}, {4'd0, pop2}, {4'd0, v.pop});
    chk({tag, " starve"}, {4'd0, starve2}, {4'd0, v.starve});
    chk({tag, " el0"}, eo2[0], v.el0);
  endtask

  initial begin
    vec_t t;
    for (int i = 0; i < 4; i++) ei[i] = 8'hA0 + 8'(i);

    v1[0]  = '{4'b1111, 2'b11, 2'b00, 4'b0000, 4'b0000, 8'h00, 8'h00};
    v1[1]  = '{4'b0000, 2'b11, 2'b11, 4'b0011, 4'b0000, 8'hA0, 8'hA1};
    v1[2]  = '{4'b0000, 2'b11, 2'b11, 4'b1100, 4'b0000, 8'hA2, 8'hA3};
    v1[3]  = '{4'b1111, 2'b11, 2'b00, 4'b0000, 4'b0000, 8'h00, 8'h00};
    v1[4]  = '{4'b0000, 2'b11, 2'b11, 4'b0011, 4'b0000, 8'hA0, 8'hA1};
    v1[5]  = '{4'b0111, 2'b10, 2'b01, 4'b0000, 4'b0000, 8'hA3, 8'h00};
    v1[6]  = '{4'b0111, 2'b10, 2'b01, 4'b0000, 4'b0000, 8'hA3, 8'h00};
    v1[7]  = '{4'b0111, 2'b10, 2'b01, 4'b0000, 4'b0000, 8'hA3, 8'h00};
    v1[8]  = '{4'b0111, 2'b11, 2'b01, 4'b1000, 4'b0000, 8'hA3, 8'h00};
    v1[9]  = '{4'b1001, 2'b10, 2'b11, 4'b0100, 4'b0000, 8'hA1, 8'hA2};
    v1[10] = '{4'b1001, 2'b10, 2'b11, 4'b0100, 4'b0000, 8'hA1, 8'hA2};
    v1[11] = '{4'b1001, 2'b11, 2'b11, 4'b0110, 4'b0000, 8'hA1, 8'hA2};
    v1[12] = '{4'b1111, 2'b11, 2'b00, 4'b0000, 4'b0000, 8'h00, 8'h00};
    v1[13] = '{4'b0000, 2'b11, 2'b11, 4'b1001, 4'b0000, 8'hA3, 8'hA0};
    v1[14] = '{4'b0000, 2'b00, 2'b11, 4'b0000, 4'b0000, 8'hA1, 8'hA2};
    v1[15] = '{4'b0000, 2'b01, 2'b11, 4'b0010, 4'b0000, 8'hA1, 8'hA2};
    v1[16] = '{4'b0000, 2'b11, 2'b11, 4'b1100, 4'b0000, 8'hA3, 8'hA2};

    v2[0] = '{4'b1110, 2'b01, 2'b01, 4'b0001, 4'b0000, 8'hA0, 8'h00};
    v2[1] = '{4'b1100, 2'b00, 2'b01, 4'b0000, 4'b0000, 8'hA1, 8'h00};
    v2[2] = '{4'b1100, 2'b00, 2'b01, 4'b0000, 4'b0000, 8'hA1, 8'h00};
    v2[3] = '{4'b1000, 2'b01, 2'b01, 4'b0010, 4'b0011, 8'hA1, 8'h00};
    v2[4] = '{4'b1000, 2'b01, 2'b01, 4'b0001, 4'b0001, 8'hA0, 8'h00};
    v2[5] = '{4'b1000, 2'b01, 2'b01, 4'b0100, 4'b0100, 8'hA2, 8'h00};

    rst_n  = 1'b0;
    empty1 = 4'b1111;
    ready1 = 2'b00;
    empty2 = 4'b1111;
    ready2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      empty1 = v1[n].empty;
      ready1 = v1[n].ready;
      #1;
      chk1($sformatf("v1[%0d]", n), v1[n]);
    end

    // Lock both sinks, then reset while they are stalled
    @(negedge clk);
    empty1 = 4'b0000;
    ready1 = 2'b00;
    #1;
    t = '{4'b0000, 2'b00, 2'b11, 4'b0000, 4'b0000, 8'hA3, 8'hA0};
    chk1("lock_pre_reset", t);

    @(negedge clk);
    rst_n  = 1'b0;
    empty1 = 4'b1011;
    #1;
    t = '{4'b1011, 2'b00, 2'b01, 4'b0000, 4'b0000, 8'hA2, 8'h00};
    chk1("in_reset", t);

    @(negedge clk);
    rst_n  = 1'b1;
    ready1 = 2'b11;
    #1;
    t = '{4'b1011, 2'b11, 2'b01, 4'b0100, 4'b0000, 8'hA2, 8'h00};
    chk1("after_reset", t);

    @(negedge clk);
    empty1 = 4'b1111;
    ready1 = 2'b00;

    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      empty2 = v2[n].empty;
      ready2 = v2[n].ready[0];
      #1;
      chk2($sformatf("v2[%0d]", n), v2[n]);
    end

    @(negedge clk);
    empty2 = 4'b1111;
    ready2 = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nfail);
    $finish;
  end

endmodule
